// File: rtl/riscv_muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit with a valid/ready request and response, a result tag, and flush.
// Latency: 1 cycle for special cases, N+2 otherwise (N = XLEN/MUL_STEP for multiply, XLEN for divide).
// Backpressure: req_ready only in IDLE; the result is held in DONE until resp_ready. `define MULDIV_EARLY_OUT_EN for data-dependent early exit.
module riscv_muldiv_seq #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CW    = $clog2(XLEN);
    localparam int MUL_N = XLEN / MUL_STEP;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          funct3_q;
    logic                neg_q;
    // Multiply: product accumulator. Divide: partial remainder in the low half.
    logic [2*XLEN-1:0]   acc_q;
    // Multiply: remaining multiplier. Divide: dividend shifting out, quotient shifting in.
    logic [XLEN-1:0]     opa_q;
    // Multiply: multiplicand shifted up each step. Divide: divisor in the low half.
    logic [2*XLEN-1:0]   opb_q;
    logic                resp_valid_q;
    logic [XLEN-1:0]     resp_data_q;
    logic [TAG_W-1:0]    resp_tag_q;

    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     opa_d;
    logic [2*XLEN-1:0]   opb_d;
    logic                last_d;

    logic                is_div, sgn_a, sgn_b, sa, sb, neg_in;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                spec_hit;
    logic [XLEN-1:0]     spec_val;

    logic [2*XLEN-1:0]   partial;
    logic [XLEN:0]       shifted;
    logic                ge;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     div_val, sign_res;

    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

    // Operand decode at accept: signedness, magnitudes, result sign and special cases.
    always_comb begin
        is_div   = req_funct3[2];
        sgn_a    = is_div ? !req_funct3[0] : (req_funct3 != 3'd3);
        sgn_b    = is_div ? !req_funct3[0] : !req_funct3[1];
        sa       = sgn_a && req_a[XLEN-1];
        sb       = sgn_b && req_b[XLEN-1];
        abs_a    = sa ? -req_a : req_a;
        abs_b    = sb ? -req_b : req_b;
        // Remainder takes the dividend's sign; product and quotient the xor.
        neg_in   = (is_div && req_funct3[1]) ? sa : (sa ^ sb);
        spec_hit = 1'b0;
        spec_val = '0;
        if (!is_div) begin
            spec_hit = (req_a == '0) || (req_b == '0);
        end else if (req_b == '0) begin
            spec_hit = 1'b1;
            spec_val = req_funct3[1] ? req_a : '1;
        end else if (!req_funct3[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b)) begin
            // Signed overflow: quotient saturates to MIN_INT, remainder is zero.
            spec_hit = 1'b1;
            spec_val = req_funct3[1] ? '0 : req_a;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0] div_start;

    // Skip leading zero bytes of |a|: start the counter (and pre-shift the dividend) past them.
    always_comb begin
        div_start = CW'(XLEN - 8);
        for (int k = 0; k < XLEN / 8; k++) begin
            if (|abs_a[8*k +: 8]) div_start = CW'(XLEN - 8 * (k + 1));
        end
    end
`endif

    // One CALC iteration: shift-add multiply step or one restoring-division step.
    always_comb begin
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        last_d  = 1'b0;
        partial = '0;
        shifted = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        ge      = 1'b0;
        if (!funct3_q[2]) begin
            for (int k = 0; k < MUL_STEP; k++) begin
                if (opa_q[k]) partial = partial + (opb_q << k);
            end
            acc_d = acc_q + partial;
            opa_d = opa_q >> MUL_STEP;
            opb_d = opb_q << MUL_STEP;
`ifdef MULDIV_EARLY_OUT_EN
            last_d = (opa_d == '0);
`else
            last_d = (cnt_q == CW'(MUL_N - 1));
`endif
        end else begin
            // Compare at XLEN+1 bits unsigned so a large remainder never looks negative.
            ge     = (shifted >= {1'b0, opb_q[XLEN-1:0]});
            acc_d  = {{XLEN{1'b0}}, (ge ? XLEN'(shifted - {1'b0, opb_q[XLEN-1:0]}) : shifted[XLEN-1:0])};
            opa_d  = {opa_q[XLEN-2:0], ge};
            last_d = (cnt_q == CW'(XLEN - 1));
        end
    end

    // SIGN stage: negate per the latched flag and pick the requested half / quotient / remainder.
    always_comb begin
        prod_s   = neg_q ? -acc_q : acc_q;
        div_val  = funct3_q[1] ? acc_q[XLEN-1:0] : opa_q;
        sign_res = (funct3_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        if (funct3_q[2]) sign_res = neg_q ? -div_val : div_val;
    end

    // Control FSM and datapath registers; flush overrides every other transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        neg_q      <= neg_in;
                        resp_tag_q <= req_tag;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        if (spec_hit) begin
                            resp_data_q  <= spec_val;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (!is_div) begin
                            opa_q   <= abs_b;
                            opb_q   <= {{XLEN{1'b0}}, abs_a};
                            state_q <= S_CALC;
                        end else begin
`ifdef MULDIV_EARLY_OUT_EN
                            opa_q <= abs_a << div_start;
                            cnt_q <= div_start;
`else
                            opa_q <= abs_a;
`endif
                            opb_q   <= {{XLEN{1'b0}}, abs_b};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    resp_data_q  <= sign_res;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Scoreboard bench for riscv_muldiv_seq (XLEN=32, MUL_STEP=2).
// Expected results come from a behavioural reference model; latency measured from the accept edge.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_riscv_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    riscv_muldiv_seq #(.XLEN(32), .MUL_STEP(2), .TAG_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return (a == 0) || (b == 0);
        if (b == 0) return 1'b1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic        [63:0] u;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                r = sa / sb;
                return r;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb;
                return r;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (is_special(f3, a, b)) return 1;
        return f3[2] ? 34 : 18;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; returns at a falling edge (after the handshake if resp_ready is high).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        exp_t e;
        int   lat;
        int   w;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.data = ref_res(f3, a, b);
        e.tag  = tag;
        e.lat  = exp_lat(f3, a, b);
        sb_q.push_back(e);
        @(negedge clock);
        // Scramble inputs after accept; the unit must have captured them.
        req_valid  = 1'b0;
        req_a      = $urandom;
        req_b      = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        req_tag    = 5'($urandom_range(0, 31));
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        e = sb_q.pop_front();
        if (!resp_valid) begin
            chk($sformatf("resp_timeout f3=%0d", f3), 64'd0, 64'd1);
            return;
        end
        chk($sformatf("data f3=%0d a=%0h b=%0h", f3, a, b), {32'b0, resp_data}, {32'b0, e.data});
        chk($sformatf("tag f3=%0d", f3), {59'b0, resp_tag}, {59'b0, e.tag});
`ifdef MULDIV_EARLY_OUT_EN
        chk($sformatf("lat_bound f3=%0d lat=%0d", f3, lat), {63'b0, (lat <= e.lat) && (lat >= ((e.lat == 1) ? 1 : 3))}, 64'd1);
`else
        chk($sformatf("latency f3=%0d", f3), 64'(lat), 64'(e.lat));
`endif
        if (resp_ready) @(negedge clock);
    endtask

    // Watch for any response for a number of cycles where none must appear.
    task automatic expect_silence(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_exp;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_tag    = 5'd0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst req_ready",  {63'b0, req_ready},  64'd1);
        chk("rst resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst resp_data",  {32'b0, resp_data},  64'd0);
        chk("rst resp_tag",   {59'b0, resp_tag},   64'd0);
        chk("rst busy",       {63'b0, busy},       64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases: normal multiply/divide and the special short-cuts.
        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd6);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8);
        run_op(3'd5, 32'd100,       32'd7,         5'd9);
        run_op(3'd4, 32'd1234,      32'd0,         5'd10);
        run_op(3'd7, 32'd5,         32'd0,         5'd11);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(3'd0, 32'd0,         32'd55,        5'd14);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd1,         5'd15);

        // Flush five cycles into a divide: no response, unit idle, next op unaffected.
        req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd30;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        flush = 1'b1;
        chk("flush req_ready", {63'b0, req_ready}, 64'd0);
        @(negedge clock);
        flush = 1'b0;
        chk("flush busy",       {63'b0, busy},       64'd0);
        chk("flush resp_valid", {63'b0, resp_valid}, 64'd0);
        expect_silence("flush no_resp", 40);
        run_op(3'd0, 32'd3, 32'd4, 5'd21);

        // Flush and request together while idle: flush wins, nothing is accepted.
        flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd1;
        @(negedge clock);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_vs_accept busy", {63'b0, busy}, 64'd0);
        expect_silence("flush_vs_accept no_resp", 20);

        // Asynchronous reset mid-operation aborts without a response.
        req_valid = 1'b1; req_funct3 = 3'd5; req_a = 32'd5000; req_b = 32'd7; req_tag = 5'd2;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_rst busy",       {63'b0, busy},       64'd0);
        chk("async_rst resp_valid", {63'b0, resp_valid}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        expect_silence("async_rst no_resp", 40);

        // Backpressure: hold the result for 10 cycles, then release.
        resp_ready = 1'b0;
        hold_exp = ref_res(3'd5, 32'd1000, 32'd10);
        run_op(3'd5, 32'd1000, 32'd10, 5'd17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold valid",     {63'b0, resp_valid}, 64'd1);
            chk("hold data",      {32'b0, resp_data},  {32'b0, hold_exp});
            chk("hold tag",       {59'b0, resp_tag},   64'd17);
            chk("hold req_ready", {63'b0, req_ready},  64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk("release resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("release busy",       {63'b0, busy},       64'd0);
        chk("release req_ready",  {63'b0, req_ready},  64'd1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18);

        // Random mix of operations and corner operands.
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
        end

        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
